// File: rtl/latch_loader_pkg.sv
// Shared types and default constants for the latch loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package latch_loader_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_SETUP_CYCLES = 1;
    localparam int DEF_HOLD_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/latch_loader_phase_timer.sv
// Down-counter that times one SETUP or LOAD phase and pulses expire in its last cycle.
// Latency: start at edge N loads the count; expire is high in the (load_val+1)-th cycle after.
// Backpressure: none; start always wins and restarts the count.
module phase_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt;
    logic          active;

    // Count down from load_val while active; stop once the final cycle has been flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= load_val;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    assign expire = active && (cnt == '0);

endmodule

// File: rtl/latch_loader.sv
// Serializes words MSB first onto data, qualifying each bit with a load pulse for a level latch.
// Latency: accept -> done after NBITS*(SETUP_CYCLES+HOLD_CYCLES+1)+1 cycles; NBITS=WIDTH(+1 with LATCH_LOADER_PARITY_EN).
// Backpressure: in_ready only in IDLE; in_valid elsewhere is ignored, so words are separated by an IDLE cycle.
module latch_loader
    import latch_loader_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data,
    output logic             load,
    output logic             busy,
    output logic             done
);

`ifdef LATCH_LOADER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    // Timer holds phase length minus one; bit counter holds index of last bit.
    localparam int MAXC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CW   = cnt_w(MAXC - 1);
    localparam int BW   = cnt_w(NBITS - 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(NBITS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] word;
    logic            data_q;
    logic            accept;
    logic            last_bit;
    logic            tmr_start;
    logic [CW-1:0]   tmr_load;
    logic            tmr_expire;

`ifdef LATCH_LOADER_PARITY_EN
    // Even parity trails the LSB as an extra bit.
    assign word = {in_data, ^in_data};
`else
    assign word = in_data;
`endif

    assign accept   = in_valid && (state == ST_IDLE);
    assign last_bit = (bit_cnt == LAST_IDX);

    phase_timer #(
        .CW (CW)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .load_val (tmr_load),
        .expire   (tmr_expire)
    );

    // State register; reset drops straight to IDLE so load falls asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the timer is started on every edge that enters SETUP or LOAD.
    always_comb begin
        state_nxt = state;
        tmr_start = 1'b0;
        tmr_load  = SETUP_LD;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    tmr_start = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    state_nxt = ST_LOAD;
                    tmr_start = 1'b1;
                    tmr_load  = HOLD_LD;
                end
            end
            ST_LOAD: begin
                if (tmr_expire) begin
                    state_nxt = ST_TRAIL;
                end
            end
            ST_TRAIL: begin
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETUP;
                    tmr_start = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: data changes only on the edges that enter SETUP, and clears on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            data_q  <= word[NBITS-1];
            shreg   <= word << 1;
            bit_cnt <= '0;
        end else if (state == ST_TRAIL) begin
            if (last_bit) begin
                data_q <= 1'b0;
            end else begin
                data_q  <= shreg[NBITS-1];
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    assign data     = data_q;
    assign load     = (state == ST_LOAD);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign in_ready = (state == ST_IDLE);

endmodule

// File: doc/latch_loader.md
LATCH_LOADER -- requirements
Module: latch_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter WIDTH, default 8, sets the word width in bits; legal range is 2..32.
REQ-003 Parameter SETUP_CYCLES, default 1, sets the cycles data is stable with load low before load rises; minimum 1.
REQ-004 Parameter HOLD_CYCLES, default 2, sets the cycles load stays high per bit; minimum 1.
REQ-005 Port list (name, direction, width, meaning), clock and reset first:
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- in_data, in, WIDTH, word to transmit.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block can accept a word.
- data, out, 1, serial bit to the level-sensitive latch.
- load, out, 1, latch enable, active high.
- busy, out, 1, a transfer is in progress.
- done, out, 1, one-cycle end-of-word pulse.

Function
REQ-006 The block SHALL be the driving end of the data/load latch interface; it serializes words MSB first onto data and qualifies each bit with a load pulse.
REQ-007 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data SHALL be captured only at that edge.
REQ-008 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-009 The FSM states SHALL be IDLE, SETUP, LOAD, TRAIL and DONE.
REQ-010 FSM transitions:
- IDLE to SETUP on accept.
- SETUP to LOAD after SETUP_CYCLES.
- LOAD to TRAIL after HOLD_CYCLES.
- TRAIL lasts 1 cycle, then goes to SETUP for the next bit, or to DONE after the last bit.
- DONE lasts 1 cycle, then goes to IDLE.
REQ-011 data SHALL hold the current bit for the whole of SETUP, LOAD and TRAIL.
- data changes only on entry to SETUP.
- In TRAIL, load=0 while data is still held, so the latch never sees data change while load is high.
REQ-012 load SHALL be 1 only in LOAD.
REQ-013 Each bit SHALL take exactly SETUP_CYCLES+HOLD_CYCLES+1 cycles.
REQ-014 done SHALL be 1 only in DONE.
REQ-015 busy SHALL be 1 in SETUP, LOAD, TRAIL and DONE.
REQ-016 The bit counter and the cycle counter SHALL each be sized to their maximum value; neither SHALL wrap during a word.
REQ-017 In IDLE and DONE, data SHALL be 0.
REQ-018 A new word SHALL NOT be accepted in DONE; back-to-back words are separated by at least one IDLE cycle.

Reset
REQ-019 While rst_n=0, the outputs SHALL be: data=0, load=0, busy=0, done=0, in_ready=1, state=IDLE, counters=0.
REQ-020 Reset asserted mid-word SHALL drop load immediately (asynchronously) and abort the word; no partial-word resumption is allowed.
REQ-021 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-022 Macro LATCH_LOADER_PARITY_EN controls a parity bit:
- Defined: after the LSB, one extra bit carrying the even parity (XOR of all WIDTH bits) SHALL be sent with identical SETUP/LOAD/TRAIL timing; a word is WIDTH+1 bits.
- Undefined: no parity logic is present; a word is exactly WIDTH bits.

Structure
REQ-023 Package latch_loader_pkg SHALL hold the state enum typedef and the default constants for WIDTH, SETUP_CYCLES and HOLD_CYCLES.
REQ-024 The per-phase down-counter SHALL be a sub-module, phase_timer (load value, start, expire pulse), reused for both SETUP and LOAD.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Basic word: WIDTH=8, SETUP=1, HOLD=2, accept 0xA5. Required: data = 1,0,1,0,0,1,0,1; each load high 2 cycles; done at cycle 33 after accept; in_ready back high at cycle 34.
- Parity: with LATCH_LOADER_PARITY_EN, 0xA5 sends a 9th bit = 0 and done at cycle 37; 0x07 sends a 9th bit = 1.
- Setup/trail checks: data never changes while load=1; every load rise is preceded by SETUP cycles of stable data; every load fall is followed by 1 cycle of stable data.
- Busy-time stimulus: in_valid pulsed with 0xFF while busy is ignored; only the originally accepted word appears on data.
- Reset mid-word: rst_n dropped during LOAD of bit 3. Required: load=0 in the same cycle, data=0, in_ready=1; the next word sends cleanly from its MSB.
- Timing extremes: SETUP=3, HOLD=1, 0x80. Required: 5 cycles per bit; only bit 7 is high.
